// File: rtl/main_memory_responder.sv
// Behavioural main memory behind the cache line-fill miss port: one request, fixed latency, one-cycle response.
// Optional feature macro MAIN_MEMORY_BUS_ERROR_EN: out-of-range line addresses answer with a bus error instead of wrapping.
module main_memory_responder #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 26,
  parameter int MEM_LINES  = 4096,
  parameter int LATENCY    = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_is_store,
  input  logic [LINE_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [LINE_WIDTH-1:0] rsp_data,
  output logic                  rsp_bus_error
);

  localparam int         IDX_W      = $clog2(MEM_LINES);
  localparam logic [7:0] LOAD_COUNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [7:0]            counter;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_is_store;
  logic [LINE_WIDTH-1:0] cap_data;
  logic                  cap_err;

  logic [LINE_WIDTH-1:0] mem [MEM_LINES];

  logic [ADDR_WIDTH-1:0] look_addr;
  logic                  look_store;
  logic                  look_err;
  logic [LINE_WIDTH-1:0] look_line;
  logic [LINE_WIDTH-1:0] resp_line;

  // While idle the lookup follows the live request so a LATENCY of 1 can answer straight from acceptance.
  always_comb begin
    look_addr  = cap_addr;
    look_store = cap_is_store;
    if (state == IDLE) begin
      look_addr  = req_addr;
      look_store = req_is_store;
    end
  end

  assign look_line = mem[look_addr[IDX_W-1:0]];

`ifdef MAIN_MEMORY_BUS_ERROR_EN
  assign look_err = |look_addr[ADDR_WIDTH-1:IDX_W];
`else
  logic unused_upper_addr;
  assign look_err          = 1'b0;
  assign unused_upper_addr = ^look_addr[ADDR_WIDTH-1:IDX_W];
`endif

  assign resp_line = (look_store || look_err) ? '0 : look_line;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter       <= 8'd0;
      cap_addr      <= '0;
      cap_is_store  <= 1'b0;
      cap_data      <= '0;
      cap_err       <= 1'b0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid     <= 1'b0;
          rsp_data      <= '0;
          rsp_bus_error <= 1'b0;
          if (req_valid) begin
            cap_addr     <= req_addr;
            cap_is_store <= req_is_store;
            cap_data     <= req_data;
            cap_err      <= look_err;
            counter      <= LOAD_COUNT;
            req_ready    <= 1'b0;
            if (LATENCY == 1) begin
              state         <= RESP;
              rsp_valid     <= 1'b1;
              rsp_data      <= resp_line;
              rsp_bus_error <= look_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          counter <= counter - 8'd1;
          if (counter == 8'd1) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_data      <= resp_line;
            rsp_bus_error <= look_err;
          end
        end
        RESP: begin
          state         <= IDLE;
          counter       <= 8'd0;
          req_ready     <= 1'b1;
          rsp_valid     <= 1'b0;
          rsp_data      <= '0;
          rsp_bus_error <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stores commit on the edge leaving RESP; an asynchronous reset forces IDLE first, so an aborted store never lands.
  always_ff @(posedge clock) begin
    if (state == RESP && cap_is_store && !cap_err) begin
      mem[cap_addr[IDX_W-1:0]] <= cap_data;
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: a LATENCY=10 and a LATENCY=1 instance against an array-based reference model.
module tb_main_memory_responder;

  localparam int LAT_A = 10;
  localparam int LAT_B = 1;
  localparam int LINES = 4096;
  localparam logic [127:0] A5 = {16{8'hA5}};

  logic         clock;
  logic         reset;
  logic         a_req_valid, a_req_is_store, a_req_ready, a_rsp_valid, a_rsp_bus_error;
  logic [25:0]  a_req_addr;
  logic [127:0] a_req_data, a_rsp_data;
  logic         b_req_valid, b_req_is_store, b_req_ready, b_rsp_valid, b_rsp_bus_error;
  logic [25:0]  b_req_addr;
  logic [127:0] b_req_data, b_rsp_data;

  int checks = 0;
  int failures = 0;

  logic [127:0] ref_a [int];
  logic [127:0] ref_b [int];

  bit           r_to;
  int           r_first, r_pulses, r_dirty;
  logic [31:0]  r_vmask, r_rmask;
  logic [127:0] r_data;
  logic         r_err;
  time          r_tacc;

  main_memory_responder #(.LINE_WIDTH(128), .ADDR_WIDTH(26), .MEM_LINES(LINES), .LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset(reset), .req_valid(a_req_valid), .req_addr(a_req_addr),
    .req_is_store(a_req_is_store), .req_data(a_req_data), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_bus_error(a_rsp_bus_error));

  main_memory_responder #(.LINE_WIDTH(128), .ADDR_WIDTH(26), .MEM_LINES(LINES), .LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_addr(b_req_addr),
    .req_is_store(b_req_is_store), .req_data(b_req_data), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_bus_error(b_rsp_bus_error));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: lines addressed modulo LINES, out-of-range addresses are errors only when the feature is built in.
  function automatic void model_txn(input bit sel, input logic [25:0] addr, input logic st,
                                    input logic [127:0] data, output logic [127:0] ed, output logic ee);
    int idx;
    idx = int'(addr) % LINES;
    ed = '0;
    ee = 1'b0;
`ifdef MAIN_MEMORY_BUS_ERROR_EN
    if (int'(addr) >= LINES) begin
      ee = 1'b1;
      return;
    end
`endif
    if (st) begin
      if (sel) ref_b[idx] = data;
      else     ref_a[idx] = data;
    end else begin
      ed = sel ? ref_b[idx] : ref_a[idx];
    end
  endfunction

  task automatic set_req(input bit sel, input logic v, input logic [25:0] addr, input logic st, input logic [127:0] data);
    if (sel) begin
      b_req_valid = v; b_req_addr = addr; b_req_is_store = st; b_req_data = data;
    end else begin
      a_req_valid = v; a_req_addr = addr; a_req_is_store = st; a_req_data = data;
    end
  endtask

  // Issues one request and records what the responder does over the following lat+1+extra cycles.
  task automatic run_txn(input bit sel, input int lat, input logic [25:0] addr, input logic st,
                         input logic [127:0] data, input int intrude_at, input logic [25:0] intrude_addr,
                         input int extra);
    logic rv, re, rr;
    logic [127:0] rd;
    int n;
    r_to = 0; r_first = -1; r_pulses = 0; r_dirty = 0;
    r_vmask = '0; r_rmask = '0; r_data = '0; r_err = 1'b0; r_tacc = 0;
    n = 0;
    rr = sel ? b_req_ready : a_req_ready;
    while (!rr && n < 50) begin
      @(negedge clock);
      rr = sel ? b_req_ready : a_req_ready;
      n++;
    end
    if (!rr) begin
      r_to = 1;
      return;
    end
    set_req(sel, 1'b1, addr, st, data);
    @(posedge clock);
    r_tacc = $time;
    #1 set_req(sel, 1'b0, '0, 1'b0, '0);
    for (int k = 1; k <= lat + 1 + extra; k++) begin
      @(negedge clock);
      if (k == intrude_at)          set_req(sel, 1'b1, intrude_addr, 1'b0, '0);
      else if (k == intrude_at + 1) set_req(sel, 1'b0, '0, 1'b0, '0);
      rv = sel ? b_rsp_valid : a_rsp_valid;
      rd = sel ? b_rsp_data : a_rsp_data;
      re = sel ? b_rsp_bus_error : a_rsp_bus_error;
      rr = sel ? b_req_ready : a_req_ready;
      if (k < 32) begin
        r_vmask[k] = rv;
        r_rmask[k] = rr;
      end
      if (rv) begin
        r_pulses++;
        if (r_first < 0) begin
          r_first = k; r_data = rd; r_err = re;
        end
      end else if (rd !== '0 || re !== 1'b0) begin
        r_dirty++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_a_ready got=%b exp=1", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_a_valid got=%b exp=0", a_rsp_valid); end
    checks++; if (a_rsp_data !== '0) begin failures++; $display("[TB] FAIL reset_a_data got=%h exp=0", a_rsp_data); end
    checks++; if (a_rsp_bus_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_a_err got=%b exp=0", a_rsp_bus_error); end
    checks++; if (b_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_b_ready got=%b exp=1", b_req_ready); end
    checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_b_valid got=%b exp=0", b_rsp_valid); end
    checks++; if (b_rsp_data !== '0) begin failures++; $display("[TB] FAIL reset_b_data got=%h exp=0", b_rsp_data); end
    checks++; if (b_rsp_bus_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_b_err got=%b exp=0", b_rsp_bus_error); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_read_after_reset;
    logic [127:0] ed;
    logic ee;
    logic [31:0] exp_v, exp_r;
    exp_v = 32'd1 << LAT_A;
    exp_r = 32'd1 << (LAT_A + 1);
    model_txn(0, 26'd5, 1'b1, A5, ed, ee);
    run_txn(0, LAT_A, 26'd5, 1'b1, A5, 0, '0, 0);
    checks++; if (r_to !== 1'b0) begin failures++; $display("[TB] FAIL preload5_timeout got=%b exp=0", r_to); end
    checks++; if (r_first != LAT_A) begin failures++; $display("[TB] FAIL preload5_latency got=%0d exp=%0d", r_first, LAT_A); end
    checks++; if (r_data !== '0) begin failures++; $display("[TB] FAIL preload5_data got=%h exp=0", r_data); end
    model_txn(0, 26'd5, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd5, 1'b0, '0, 0, '0, 0);
    checks++; if (r_vmask !== exp_v) begin failures++; $display("[TB] FAIL read5_valid_cycles got=%h exp=%h", r_vmask, exp_v); end
    checks++; if (r_rmask !== exp_r) begin failures++; $display("[TB] FAIL read5_ready_cycles got=%h exp=%h", r_rmask, exp_r); end
    checks++; if (r_data !== A5) begin failures++; $display("[TB] FAIL read5_data got=%h exp=%h", r_data, A5); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("[TB] FAIL read5_err got=%b exp=0", r_err); end
    checks++; if (r_dirty != 0) begin failures++; $display("[TB] FAIL read5_idle_outputs got=%0d exp=0", r_dirty); end
  endtask

  task automatic test_store_then_read;
    logic [127:0] ed;
    logic ee;
    model_txn(0, 26'd7, 1'b1, 128'h1234, ed, ee);
    run_txn(0, LAT_A, 26'd7, 1'b1, 128'h1234, 0, '0, 0);
    checks++; if (r_first != LAT_A) begin failures++; $display("[TB] FAIL store7_latency got=%0d exp=%0d", r_first, LAT_A); end
    checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL store7_data got=%h exp=%h", r_data, ed); end
    model_txn(0, 26'd7, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd7, 1'b0, '0, 0, '0, 0);
    checks++; if (r_first != LAT_A) begin failures++; $display("[TB] FAIL read7_latency got=%0d exp=%0d", r_first, LAT_A); end
    checks++; if (r_data !== 128'h1234) begin failures++; $display("[TB] FAIL read7_data got=%h exp=%h", r_data, 128'h1234); end
  endtask

  task automatic test_busy_request;
    logic [127:0] ed;
    logic ee;
    model_txn(0, 26'd9, 1'b1, {8{16'h9999}}, ed, ee);
    run_txn(0, LAT_A, 26'd9, 1'b1, {8{16'h9999}}, 0, '0, 0);
    model_txn(0, 26'd5, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd5, 1'b0, '0, 3, 26'd9, 15);
    checks++; if (r_pulses != 1) begin failures++; $display("[TB] FAIL busy_pulse_count got=%0d exp=1", r_pulses); end
    checks++; if (r_first != LAT_A) begin failures++; $display("[TB] FAIL busy_latency got=%0d exp=%0d", r_first, LAT_A); end
    checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL busy_data got=%h exp=%h", r_data, ed); end
  endtask

  task automatic test_latency_one;
    logic [127:0] ed, d0;
    logic ee;
    logic [31:0] exp_v, exp_r;
    time t1;
    exp_v = 32'd1 << LAT_B;
    exp_r = 32'd1 << (LAT_B + 1);
    d0 = {$urandom, $urandom, $urandom, $urandom};
    model_txn(1, 26'd0, 1'b1, d0, ed, ee);
    run_txn(1, LAT_B, 26'd0, 1'b1, d0, 0, '0, 0);
    checks++; if (r_first != LAT_B) begin failures++; $display("[TB] FAIL lat1_store_latency got=%0d exp=%0d", r_first, LAT_B); end
    model_txn(1, 26'd0, 1'b0, '0, ed, ee);
    run_txn(1, LAT_B, 26'd0, 1'b0, '0, 0, '0, 0);
    t1 = r_tacc;
    checks++; if (r_vmask !== exp_v) begin failures++; $display("[TB] FAIL lat1_valid_cycles got=%h exp=%h", r_vmask, exp_v); end
    checks++; if (r_rmask !== exp_r) begin failures++; $display("[TB] FAIL lat1_ready_cycles got=%h exp=%h", r_rmask, exp_r); end
    checks++; if (r_data !== d0) begin failures++; $display("[TB] FAIL lat1_read_data got=%h exp=%h", r_data, d0); end
    run_txn(1, LAT_B, 26'd0, 1'b0, '0, 0, '0, 0);
    checks++; if (r_tacc - t1 != 64'd20) begin failures++; $display("[TB] FAIL lat1_spacing got=%0t exp=20", r_tacc - t1); end
    checks++; if (r_data !== d0) begin failures++; $display("[TB] FAIL lat1_second_data got=%h exp=%h", r_data, d0); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] ed;
    logic ee;
    time t1;
    model_txn(0, 26'd7, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd7, 1'b0, '0, 0, '0, 0);
    t1 = r_tacc;
    checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL b2b_first_data got=%h exp=%h", r_data, ed); end
    model_txn(0, 26'd5, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd5, 1'b0, '0, 0, '0, 0);
    checks++; if (r_tacc - t1 != 64'd110) begin failures++; $display("[TB] FAIL b2b_spacing got=%0t exp=110", r_tacc - t1); end
    checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL b2b_second_data got=%h exp=%h", r_data, ed); end
  endtask

  task automatic test_mid_reset;
    logic [127:0] ed;
    logic ee;
    int pulses;
    model_txn(0, 26'd3, 1'b1, '0, ed, ee);
    run_txn(0, LAT_A, 26'd3, 1'b1, '0, 0, '0, 0);
    set_req(0, 1'b1, 26'd3, 1'b1, '1);
    @(posedge clock);
    #1 set_req(0, 1'b0, '0, 1'b0, '0);
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b exp=0", a_rsp_valid); end
    checks++; if (a_rsp_data !== '0) begin failures++; $display("[TB] FAIL midrst_data got=%h exp=0", a_rsp_data); end
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%b exp=1", a_req_ready); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (a_rsp_valid) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL midrst_stray_response got=%0d exp=0", pulses); end
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready_after got=%b exp=1", a_req_ready); end
    model_txn(0, 26'd3, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd3, 1'b0, '0, 0, '0, 0);
    checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL midrst_read3 got=%h exp=%h", r_data, ed); end
  endtask

  task automatic test_bus_error;
    logic [127:0] ed, d0;
    logic ee;
    d0 = {$urandom, $urandom, $urandom, $urandom};
    model_txn(0, 26'd0, 1'b1, d0, ed, ee);
    run_txn(0, LAT_A, 26'd0, 1'b1, d0, 0, '0, 0);
    model_txn(0, 26'd4096, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd4096, 1'b0, '0, 0, '0, 0);
    checks++; if (r_first != LAT_A) begin failures++; $display("[TB] FAIL hiaddr_read_latency got=%0d exp=%0d", r_first, LAT_A); end
    checks++; if (r_err !== ee) begin failures++; $display("[TB] FAIL hiaddr_read_err got=%b exp=%b", r_err, ee); end
    checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL hiaddr_read_data got=%h exp=%h", r_data, ed); end
    model_txn(0, 26'd4096, 1'b1, ~d0, ed, ee);
    run_txn(0, LAT_A, 26'd4096, 1'b1, ~d0, 0, '0, 0);
    checks++; if (r_err !== ee) begin failures++; $display("[TB] FAIL hiaddr_store_err got=%b exp=%b", r_err, ee); end
    model_txn(0, 26'd0, 1'b0, '0, ed, ee);
    run_txn(0, LAT_A, 26'd0, 1'b0, '0, 0, '0, 0);
    checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL line0_after_hiaddr_store got=%h exp=%h", r_data, ed); end
  endtask

  task automatic test_random;
    logic [127:0] ed, d;
    logic ee, st;
    logic [25:0] addr;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      model_txn(0, 26'(i), 1'b1, d, ed, ee);
      run_txn(0, LAT_A, 26'(i), 1'b1, d, 0, '0, 0);
    end
    for (int i = 0; i < 30; i++) begin
      addr = 26'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) addr = addr | (26'($urandom_range(1, 16383)) << 12);
      st = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      model_txn(0, addr, st, d, ed, ee);
      run_txn(0, LAT_A, addr, st, d, 0, '0, 0);
      checks++; if (r_to !== 1'b0 || r_first != LAT_A) begin failures++; $display("[TB] FAIL rand%0d_latency got=%0d exp=%0d", i, r_first, LAT_A); end
      checks++; if (r_data !== ed) begin failures++; $display("[TB] FAIL rand%0d_data addr=%h got=%h exp=%h", i, addr, r_data, ed); end
      checks++; if (r_err !== ee) begin failures++; $display("[TB] FAIL rand%0d_err addr=%h got=%b exp=%b", i, addr, r_err, ee); end
    end
  endtask

  initial begin
    set_req(0, 1'b0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0);
    test_reset;
    test_read_after_reset;
    test_store_then_read;
    test_busy_request;
    test_latency_one;
    test_back_to_back;
    test_mid_reset;
    test_bus_error;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Memory-side responder for the cache line-fill protocol. Accepts one line request (read or store) from a cache miss port and holds it for a fixed latency.
- Then returns a full line, or a bus error, with a single-cycle response pulse.
- Sits behind the instruction/data cache miss interfaces as the behavioural main memory model.

Parameters:
- LINE_WIDTH, 128, bits per cache line; req_data and rsp_data width.
- ADDR_WIDTH, 26, width of the line address (byte address already right-shifted by line size).
- MEM_LINES, 4096, number of lines in the backing array; power of two.
- LATENCY, 10, cycles from request acceptance to response; legal range 1..255.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- req_valid  in  1  request strobe; sampled only when req_ready=1.
- req_addr  in  ADDR_WIDTH  line address.
- req_is_store  in  1  1 = write req_data to line, 0 = read line.
- req_data  in  LINE_WIDTH  store data; ignored for reads.
- req_ready  out  1  responder idle and able to accept a request this cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  LINE_WIDTH  read line; 0 for stores and errors.
- rsp_bus_error  out  1  qualifies rsp_valid; request failed, no state change.

Behaviour:
- States: IDLE, WAIT, RESP. Registered state, counter (8 bits), and captured addr, is_store, data.
- Reset (reset=0, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_bus_error=0; rsp_data=0; counter=0.
  - Array contents are NOT reset and are preserved across reset.
- IDLE: req_ready=1.
  - On req_valid=1: capture the request, load counter=LATENCY-1, go to WAIT (or to RESP directly if LATENCY=1).
- WAIT: req_ready=0.
  - Counter decrements each cycle; at counter==1 go to RESP.
  - req_valid while busy is a protocol violation: ignored, never queued.
- RESP: lasts exactly one cycle. rsp_valid=1; then return to IDLE.
- Latency: request accepted at edge T gives rsp_valid high in the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- No new request is accepted in the RESP cycle. The earliest next acceptance is the cycle after RESP, so back-to-back requests are spaced LATENCY+1 cycles apart.
- Read response: rsp_data = array[captured addr mod MEM_LINES], sampled in the RESP cycle.
- Store response:
  - The array line is written at the RESP edge; rsp_data=0.
  - A read accepted after that store returns the new data.
- rsp_data and rsp_bus_error are 0 whenever rsp_valid=0.
- Reset during WAIT or RESP: response is aborted with no rsp_valid; a pending store is not committed.
- Address wrap: upper address bits above log2(MEM_LINES) are discarded, unless the optional feature is enabled.

Optional Feature:
- Macro: MAIN_MEMORY_BUS_ERROR_EN.
- Defined:
  - A request with req_addr >= MEM_LINES still takes the full LATENCY.
  - Its response has rsp_valid=1, rsp_bus_error=1, rsp_data=0.
  - A store to such an address is discarded and the array is unchanged.
- Undefined: rsp_bus_error is tied to 0 and addresses wrap modulo MEM_LINES.

Test Plan:
- Read after reset with LATENCY=10:
  - Preload array[5]=128'hA5..A5; req_valid=1, addr=5, is_store=0 accepted at cycle 0.
  - Expect req_ready=0 in cycles 1..10; rsp_valid=1 only in cycle 10, rsp_data=A5..A5, rsp_bus_error=0; req_ready=1 in cycle 11.
- Store then read:
  - Store addr=7, data=128'h1234; expect rsp_valid with rsp_data=0.
  - Then read addr=7; expect rsp_data=128'h1234 exactly LATENCY cycles after the second acceptance.
- Request while busy: pulse req_valid with addr=9 at cycle 3 of an outstanding read of addr=5 -> exactly one response, for addr 5; no response ever for addr 9.
- LATENCY=1 boundary: read addr=0 accepted at cycle 0 -> rsp_valid in cycle 1 only; next request accepted in cycle 2.
- Mid-operation reset:
  - Store addr=3 with data=FF..FF, with array[3]=0; drive reset=0 at cycle 4.
  - Expect outputs zero immediately (asynchronous), no rsp_valid, req_ready=1 after release; a subsequent read of addr 3 returns 0.
- With MAIN_MEMORY_BUS_ERROR_EN, MEM_LINES=4096:
  - Read addr=4096 -> after LATENCY, rsp_valid=1, rsp_bus_error=1, rsp_data=0.
  - Store to addr=4096 -> array[0] unchanged.
  - Without the macro, a read of addr=4096 returns array[0].
